// File: rtl/line_ring_buffer.sv
// -----------------------------------------------------------------------------
// line_ring_buffer
//
// Ring of BUFFER_SIZE line RAMs used as a vertical window for 2-D filters.
// One line at a time is written (line wp); when the producer signals
// advanceWrite, that line is committed and the next RAM in the ring becomes
// the write line. The consumer reads TAPS_Y vertically adjacent committed
// lines starting at line rp, two horizontally adjacent pixels per tap
// (x and min(x+1, clampAddress)), and retires lines with readStep.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   writeEnable     write writeData at writeAddress into the write line
//   writeAddress    pixel index within the write line
//   writeData       pixel value
//   advanceWrite    commit the write line and move to the next one
//   readEnable      issue a read access (result one cycle later)
//   readAddress     left pixel index x
//   clampAddress    last valid pixel index of the line
//   readStep        number of lines to retire this cycle (0 = none)
//   forceRead       drain mode: writes blocked, reads need no full window
//   readData0       pixel at x, tap t in slice t
//   readData1       pixel at min(x+1, clampAddress), tap t in slice t
//   readValid       readData0/readData1 carry a new access this cycle
//   fillCount       committed, unretired lines
//   full, empty     fillCount == BUFFER_SIZE / fillCount == 0
//   overflow        one-cycle pulse after a rejected advanceWrite
//   underflow       one-cycle pulse after a rejected nonzero readStep
// -----------------------------------------------------------------------------
module line_ring_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUFFER_SIZE   = 4,
  parameter int TAPS_Y        = 2,
  parameter int COUNT_WIDTH   = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            writeEnable,
  input  logic [ADDRESS_WIDTH-1:0]        writeAddress,
  input  logic [DATA_WIDTH-1:0]           writeData,
  input  logic                            advanceWrite,
  input  logic                            readEnable,
  input  logic [ADDRESS_WIDTH-1:0]        readAddress,
  input  logic [ADDRESS_WIDTH-1:0]        clampAddress,
  input  logic [$clog2(TAPS_Y+1)-1:0]     readStep,
  input  logic                            forceRead,
  output logic [TAPS_Y*DATA_WIDTH-1:0]    readData0,
  output logic [TAPS_Y*DATA_WIDTH-1:0]    readData1,
  output logic                            readValid,
  output logic [COUNT_WIDTH-1:0]          fillCount,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int PTR_WIDTH = $clog2(BUFFER_SIZE);
  localparam int DEPTH     = 2 ** ADDRESS_WIDTH;

  // Modulo-BUFFER_SIZE pointer addition. Every offset used here is smaller
  // than BUFFER_SIZE, so one conditional subtraction is enough and the ring
  // wraps correctly for non-power-of-two sizes.
  function automatic logic [PTR_WIDTH-1:0] ptr_add(
    input logic [PTR_WIDTH-1:0] base,
    input logic [PTR_WIDTH:0]   offset
  );
    logic [PTR_WIDTH:0] sum;
    sum = {1'b0, base} + offset;
    if (sum >= (PTR_WIDTH+1)'(BUFFER_SIZE)) begin
      sum = sum - (PTR_WIDTH+1)'(BUFFER_SIZE);
    end
    return sum[PTR_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0]  wp;
  logic [PTR_WIDTH-1:0]  rp;

  // NOTE: line storage has no reset; its contents are meaningless until a
  // line is written, and fillCount alone decides which lines are valid.
  logic [DATA_WIDTH-1:0] line_ram [BUFFER_SIZE][DEPTH];

  // ---------------------------------------------------------------------------
  // Acceptance decisions for this cycle
  // ---------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0]   step_ext;
  logic                     step_ok;
  logic [COUNT_WIDTH-1:0]   step_acc;
  logic [COUNT_WIDTH-1:0]   fill_after_step;
  logic                     advance_ok;
  logic [COUNT_WIDTH-1:0]   fill_next;
  logic                     write_ok;
  logic                     read_ok;
  logic [ADDRESS_WIDTH-1:0] read_address_next;
  logic [PTR_WIDTH-1:0]     tap_line [TAPS_Y];

  // NOTE: every signal gets a value on every path through always_comb, so
  // no latch can be inferred.
  always_comb begin
    step_ext        = COUNT_WIDTH'(readStep);
    step_ok         = (step_ext <= fillCount);
    step_acc        = step_ok ? step_ext : '0;

    // The read side retires first; a line freed in the same cycle makes room
    // for the advance, and both changes are netted into one update.
    fill_after_step = fillCount - step_acc;
    advance_ok      = advanceWrite && (fill_after_step < COUNT_WIDTH'(BUFFER_SIZE));
    fill_next       = fill_after_step + COUNT_WIDTH'(advance_ok);

    // When full, the write line is the oldest committed line: writing would
    // corrupt data still waiting to be read.
    write_ok        = writeEnable && !forceRead && !full;

    read_ok         = readEnable &&
                      ((fillCount >= COUNT_WIDTH'(TAPS_Y)) || forceRead);

    // Right neighbour saturates at the clamp, never wraps to pixel 0.
    read_address_next = (readAddress < clampAddress)
                        ? readAddress + ADDRESS_WIDTH'(1)
                        : clampAddress;

    for (int t = 0; t < TAPS_Y; t++) begin
      tap_line[t] = ptr_add(rp, (PTR_WIDTH+1)'(t));
    end
  end

  // ---------------------------------------------------------------------------
  // Line RAM write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && write_ok) begin
      line_ram[wp][writeAddress] <= writeData;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and status flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      fillCount <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rp        <= ptr_add(rp, (PTR_WIDTH+1)'(step_acc));
      if (advance_ok) begin
        wp <= ptr_add(wp, (PTR_WIDTH+1)'(1));
      end
      fillCount <= fill_next;
      // Flags come from the same next value as fillCount so the three can
      // never disagree.
      full      <= (fill_next == COUNT_WIDTH'(BUFFER_SIZE));
      empty     <= (fill_next == '0);
      overflow  <= advanceWrite && !advance_ok;
      underflow <= (step_ext != '0) && !step_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: one-cycle latency, outputs hold between valid accesses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readValid <= 1'b0;
      readData0 <= '0;
      readData1 <= '0;
    end else begin
      readValid <= read_ok;
      if (read_ok) begin
        for (int t = 0; t < TAPS_Y; t++) begin
          readData0[t*DATA_WIDTH +: DATA_WIDTH] <= line_ram[tap_line[t]][readAddress];
          readData1[t*DATA_WIDTH +: DATA_WIDTH] <= line_ram[tap_line[t]][read_address_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_ring_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_ring_buffer
//
// Directed scenarios followed by a random phase. The reference model keeps
// the buffer as a queue of logical lines (oldest first) plus the line being
// written; each logical line records which pixels have been written, and
// only those pixels are compared.
// -----------------------------------------------------------------------------
module tb_line_ring_buffer;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int BS   = 4;
  localparam int TY   = 2;
  localparam int CW   = $clog2(BS + 1);
  localparam int SW   = $clog2(TY + 1);
  localparam int NPIX = 2 ** AW;
  localparam int NID  = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               writeEnable;
  logic [AW-1:0]      writeAddress;
  logic [DW-1:0]      writeData;
  logic               advanceWrite;
  logic               readEnable;
  logic [AW-1:0]      readAddress;
  logic [AW-1:0]      clampAddress;
  logic [SW-1:0]      readStep;
  logic               forceRead;
  logic [TY*DW-1:0]   readData0;
  logic [TY*DW-1:0]   readData1;
  logic               readValid;
  logic [CW-1:0]      fillCount;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               underflow;

  line_ring_buffer #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .BUFFER_SIZE  (BS),
    .TAPS_Y       (TY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .writeEnable (writeEnable),
    .writeAddress(writeAddress),
    .writeData   (writeData),
    .advanceWrite(advanceWrite),
    .readEnable  (readEnable),
    .readAddress (readAddress),
    .clampAddress(clampAddress),
    .readStep    (readStep),
    .forceRead   (forceRead),
    .readData0   (readData0),
    .readData1   (readData1),
    .readValid   (readValid),
    .fillCount   (fillCount),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int            committed[$];           // logical line ids, oldest first
  int            wl_id;                  // line currently being written
  int            next_id;
  logic [DW-1:0] px_m [NID][NPIX];
  bit            kn_m [NID][NPIX];

  logic [DW-1:0] exp0 [TY];
  logic [DW-1:0] exp1 [TY];
  bit            chk0 [TY];
  bit            chk1 [TY];
  bit            exp_rv, exp_ovf, exp_unf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_line();
    wl_id   = next_id;
    next_id = (next_id + 1) % NID;
    for (int i = 0; i < NPIX; i++) kn_m[wl_id][i] = 1'b0;
  endtask

  // Apply current inputs for one clock, advance the model, check all outputs.
  task automatic tick();
    int fill;
    int s;
    int x0;
    int x1;
    if (!rst_n) begin
      committed.delete();
      new_line();
      exp_rv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      for (int t = 0; t < TY; t++) begin
        exp0[t] = '0; exp1[t] = '0; chk0[t] = 1'b1; chk1[t] = 1'b1;
      end
    end else begin
      fill    = committed.size();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      if (readEnable && (fill >= TY || forceRead)) begin
        exp_rv = 1'b1;
        x0 = int'(readAddress);
        x1 = (readAddress < clampAddress) ? int'(readAddress) + 1 : int'(clampAddress);
        for (int t = 0; t < TY; t++) begin
          if (t < fill) begin
            exp0[t] = px_m[committed[t]][x0]; chk0[t] = kn_m[committed[t]][x0];
            exp1[t] = px_m[committed[t]][x1]; chk1[t] = kn_m[committed[t]][x1];
          end else begin
            chk0[t] = 1'b0; chk1[t] = 1'b0;
          end
        end
      end else begin
        exp_rv = 1'b0;
      end
      if (writeEnable && !forceRead && fill != BS) begin
        px_m[wl_id][writeAddress] = writeData;
        kn_m[wl_id][writeAddress] = 1'b1;
      end
      s = int'(readStep);
      if (s <= fill) begin
        repeat (s) void'(committed.pop_front());
      end else begin
        exp_unf = 1'b1;
        s = 0;
      end
      if (advanceWrite) begin
        if (fill - s < BS) begin
          committed.push_back(wl_id);
          new_line();
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end

    @(posedge clk);
    #1;
    check("fillCount", fillCount, committed.size());
    check("full",      full,      committed.size() == BS);
    check("empty",     empty,     committed.size() == 0);
    check("readValid", readValid, exp_rv);
    check("overflow",  overflow,  exp_ovf);
    check("underflow", underflow, exp_unf);
    for (int t = 0; t < TY; t++) begin
      if (chk0[t]) check($sformatf("readData0[%0d]", t), readData0[t*DW +: DW], exp0[t]);
      if (chk1[t]) check($sformatf("readData1[%0d]", t), readData1[t*DW +: DW], exp1[t]);
    end
  endtask

  task automatic idle_inputs();
    writeEnable  = 1'b0;
    writeAddress = '0;
    writeData    = '0;
    advanceWrite = 1'b0;
    readEnable   = 1'b0;
    readAddress  = '0;
    clampAddress = 8'd15;
    readStep     = '0;
    forceRead    = 1'b0;
  endtask

  // Write pixels 0..15 of one line with value 16*tag + x, then commit it.
  task automatic write_line(input int tag);
    for (int x = 0; x < 16; x++) begin
      writeEnable  = 1'b1;
      writeAddress = AW'(x);
      writeData    = DW'(16 * tag + x);
      tick();
    end
    writeEnable  = 1'b0;
    advanceWrite = 1'b1;
    tick();
    advanceWrite = 1'b0;
  endtask

  task automatic do_read(input int ra, input int ca, input bit drain);
    readEnable   = 1'b1;
    readAddress  = AW'(ra);
    clampAddress = AW'(ca);
    forceRead    = drain;
    tick();
    readEnable   = 1'b0;
    forceRead    = 1'b0;
  endtask

  task automatic step(input int n);
    readStep = SW'(n);
    tick();
    readStep = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    next_id = 0;
    idle_inputs();
    rst_n = 1'b0;
    new_line();
    tick();
    tick();
    check("reset_readData0", readData0, 16'h0000);
    check("reset_empty", empty, 1'b1);
    rst_n = 1'b1;

    // Fill ramp: two lines, read x=5.
    write_line(0);
    write_line(1);
    do_read(5, 15, 1'b0);
    check("ramp_valid", readValid, 1'b1);
    check("ramp_rd0", readData0, 16'h1505);
    check("ramp_rd1", readData1, 16'h1606);
    tick();
    check("ramp_valid_drop", readValid, 1'b0);
    check("ramp_hold", readData0, 16'h1505);

    // Edge clamp.
    do_read(9, 9, 1'b0);
    check("clamp_at_edge_rd1", readData1, 16'h1909);
    check("clamp_at_edge_rd0", readData0, 16'h1909);
    do_read(8, 9, 1'b0);
    check("clamp_below_rd0", readData0, 16'h1808);
    check("clamp_below_rd1", readData1, 16'h1909);
    do_read(255, 255, 1'b0);
    check("clamp_no_wrap", readData1, readData0);

    // Full / overflow.
    write_line(2);
    write_line(3);
    check("full_count", fillCount, 4);
    check("full_flag", full, 1'b1);
    advanceWrite = 1'b1;
    tick();
    advanceWrite = 1'b0;
    check("overflow_pulse", overflow, 1'b1);
    check("overflow_count", fillCount, 4);
    tick();
    check("overflow_clear", overflow, 1'b0);
    advanceWrite = 1'b1;
    readStep     = 1;
    tick();
    advanceWrite = 1'b0;
    readStep     = 0;
    check("net_overflow", overflow, 1'b0);
    check("net_count", fillCount, 4);

    // Underflow and step 2 with wrap.
    step(1);
    step(2);
    check("pre_underflow_count", fillCount, 1);
    step(2);
    check("underflow_pulse", underflow, 1'b1);
    check("underflow_count", fillCount, 1);
    tick();
    check("underflow_clear", underflow, 1'b0);
    step(1);
    write_line(4);
    write_line(5);
    step(2);
    write_line(6);
    write_line(7);
    write_line(8);
    check("step2_pre", fillCount, 3);
    step(2);
    check("step2_count", fillCount, 1);

    // Drain: write line x=5 = 0x77 normally, then a drain read with a
    // write of 0xEE that must be dropped.
    writeEnable  = 1'b1;
    writeAddress = 8'd5;
    writeData    = 8'h77;
    tick();
    writeData    = 8'hEE;
    readEnable   = 1'b1;
    readAddress  = 8'd5;
    clampAddress = 8'd15;
    forceRead    = 1'b1;
    tick();
    check("drain_valid", readValid, 1'b1);
    check("drain_tap0", readData0[DW-1:0], 8'h85);
    idle_inputs();
    advanceWrite = 1'b1;
    tick();
    advanceWrite = 1'b0;
    do_read(5, 15, 1'b0);
    check("drain_write_dropped", readData0, 16'h7785);

    // Reset mid-stream with a read in the reset cycle.
    write_line(9);
    check("pre_reset_count", fillCount, 3);
    rst_n      = 1'b0;
    readEnable = 1'b1;
    tick();
    check("midreset_count", fillCount, 0);
    check("midreset_empty", empty, 1'b1);
    check("midreset_valid", readValid, 1'b0);
    rst_n      = 1'b1;
    readEnable = 1'b0;
    tick();

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      writeEnable  = ($urandom_range(0, 1) == 1);
      writeAddress = ($urandom_range(0, 15) == 0) ? 8'd255 : AW'($urandom_range(0, 15));
      writeData    = DW'($urandom);
      advanceWrite = ($urandom_range(0, 5) == 0);
      readEnable   = ($urandom_range(0, 1) == 1);
      readAddress  = ($urandom_range(0, 15) == 0) ? 8'd255 : AW'($urandom_range(0, 15));
      clampAddress = ($urandom_range(0, 15) == 0) ? 8'd255 : AW'($urandom_range(0, 15));
      readStep     = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 3)) : '0;
      forceRead    = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
